// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-stage elastic shifter (SLL/SRL/SRA/ROR), one shift level per stage.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);
  localparam int L = SHW;
  logic [L-1:0] v, adv;
  logic [WIDTH-1:0] d [L];
  logic [1:0] m [L];
  logic [SHW-1:0] sh [L];
  logic s [L];
  logic [L:0] src_v;
  logic [WIDTH-1:0] src_d [L+1];
  logic [1:0] src_m [L+1];
  logic [SHW-1:0] src_sh [L+1];
  logic src_s [L+1];
  logic [WIDTH-1:0] nd [L];
  // SRA fills from the sign captured at input, not from the partially shifted word
  function automatic logic [WIDTH-1:0] level(input logic [WIDTH-1:0] x, input logic [1:0] mode,
                                             input logic sgn, input logic en, input int n);
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sgn}} & ~({WIDTH{1'b1}} >> n);
    return !en ? x : mode == 2'b00 ? x << n : mode == 2'b01 ? x >> n :
           mode == 2'b10 ? (x >> n) | fill : (x >> n) | (x << (WIDTH - n));
  endfunction
  // a stage moves unless it and every stage after it are full and the output is stalled
  always_comb begin
    adv = '0;
    for (int k = 0; k < L; k++)
      adv[k] = out_ready || ((v >> k) != ({L{1'b1}} >> k));
  end
  assign in_ready = adv[0] && !flush;
  always_comb begin
    src_v = {v, in_valid && in_ready};
    src_d[0] = in_data;
    src_m[0] = in_mode;
    src_sh[0] = in_shamt;
    src_s[0] = in_data[WIDTH-1];
    for (int k = 0; k < L; k++) begin
      src_d[k+1] = d[k];
      src_m[k+1] = m[k];
      src_sh[k+1] = sh[k];
      src_s[k+1] = s[k];
    end
    for (int k = 0; k < L; k++)
      nd[k] = level(src_d[k], src_m[k], src_s[k], src_sh[k][k], 1 << k);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int k = 0; k < L; k++) begin
        d[k] <= '0;
        m[k] <= '0;
        sh[k] <= '0;
        s[k] <= 1'b0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < L; k++)
        if (adv[k]) begin
          v[k] <= src_v[k];
          d[k] <= nd[k];
          m[k] <= src_m[k];
          sh[k] <= src_sh[k];
          s[k] <= src_s[k];
        end
    end
  end
  assign out_valid = v[L-1];
  assign out_data = v[L-1] ? d[L-1] : '0;
  assign out_mode = v[L-1] ? m[L-1] : 2'b00;
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: random + directed checks of pipelined_shifter against a queue-based reference model.
module tb_pipelined_shifter;
  localparam int L = 5;
  logic clock = 0;
  always #5 clock = ~clock;
  logic reset_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic [4:0] in_shamt = 0;
  logic [1:0] in_mode = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0] out_mode;
  logic in_valid8 = 0;
  logic [7:0] in_data8 = 0;
  logic [2:0] in_shamt8 = 0;
  logic [1:0] in_mode8 = 0;
  logic in_ready8, out_valid8;
  logic [7:0] out_data8;
  logic [1:0] out_mode8;
  int errors = 0, checks = 0;
  logic [33:0] q [$];

  pipelined_shifter #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode));
  pipelined_shifter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_shamt(in_shamt8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(1'b1), .out_data(out_data8), .out_mode(out_mode8));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [63:0] x, int sh, logic [1:0] md, int w);
    logic [63:0] mask;
    mask = (64'h1 << w) - 1;
    x &= mask;
    case (md)
      2'b00: return (x << sh) & mask;
      2'b01: return x >> sh;
      2'b10: return (x >> sh) | (x[w-1] ? mask & ~(mask >> sh) : 64'h0);
      default: return ((x >> sh) | (x << (w - sh))) & mask;
    endcase
  endfunction

  function automatic logic exp_ready();
    return !flush && (q.size() < L || out_ready);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) q.delete();
    else if (flush) q.delete();
    else begin
      logic acc;
      acc = in_valid && exp_ready();
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back({in_mode, model(64'(in_data), int'(in_shamt), in_mode, 32)[31:0]});
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      if (!out_valid) begin
        chk("idle out_data", 64'(out_data), 64'h0);
        chk("idle out_mode", 64'(out_mode), 64'h0);
      end else if (q.size() == 0) chk("unexpected out_valid", 64'(out_valid), 64'h0);
      else begin
        chk("out_data", 64'(out_data), 64'(q[0][31:0]));
        chk("out_mode", 64'(out_mode), 64'(q[0][33:32]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rnd_op();
    in_data = $urandom;
    in_shamt = 5'($urandom_range(0, 31));
    in_mode = 2'($urandom_range(0, 3));
  endtask

  task automatic dir32(logic [31:0] dv, int sh, logic [1:0] md, logic [31:0] exp, string nm);
    int lat;
    in_data = dv; in_shamt = 5'(sh); in_mode = md; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(L));
    chk({nm, " data"}, 64'(out_data), 64'(exp));
    chk({nm, " mode"}, 64'(out_mode), 64'(md));
    tick();
  endtask

  task automatic dir8(logic [7:0] dv, int sh, logic [1:0] md, logic [7:0] exp, string nm);
    int lat;
    in_data8 = dv; in_shamt8 = 3'(sh); in_mode8 = md; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd3);
    chk({nm, " data"}, 64'(out_data8), 64'(exp));
    chk({nm, " mode"}, 64'(out_mode8), 64'(md));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, run, maxrun, acc;
    logic [31:0] held, dv;
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("reset out_valid", 64'(out_valid), 64'h0);
    chk("reset out_data", 64'(out_data), 64'h0);
    chk("reset out_mode", 64'(out_mode), 64'h0);
    chk("reset in_ready", 64'(in_ready), 64'h1);
    dir32(32'h0000_0001, 31, 2'b00, 32'h8000_0000, "sll31");
    dir32(32'h8000_00F0, 4, 2'b10, 32'hF800_000F, "sra4");
    dir32(32'h8000_00F0, 4, 2'b01, 32'h0800_000F, "srl4");
    dir32(32'h0000_0001, 1, 2'b11, 32'h8000_0000, "ror1");
    dir32(32'h8000_00F0, 0, 2'b10, 32'h8000_00F0, "sra0");
    dir32(32'h1234_5678, 8, 2'b11, 32'h7812_3456, "ror8");
    dir8(8'h01, 7, 2'b00, 8'h80, "w8 sll7");
    dir8(8'h01, 1, 2'b11, 8'h80, "w8 ror1");
    dir8(8'h90, 2, 2'b10, 8'hE4, "w8 sra2");
    n = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = c < 8;
      if (c < 8) begin
        rnd_op();
        chk("b2b in_ready", 64'(in_ready), 64'h1);
      end
      tick();
      if (out_valid) begin
        n++;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("b2b count", 64'(n), 64'd8);
    chk("b2b consecutive", 64'(maxrun), 64'd8);
    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1;
      rnd_op();
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    chk("stall accepted", 64'(acc), 64'(L));
    chk("stall in_ready", 64'(in_ready), 64'h0);
    held = out_data;
    repeat (3) tick();
    chk("stall hold", 64'(out_data), 64'(held));
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      chk("drain valid", 64'(out_valid), 64'h1);
      tick();
    end
    chk("drain done", 64'(out_valid), 64'h0);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1;
      rnd_op();
      tick();
    end
    in_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush out_valid", 64'(out_valid), 64'h0);
    n = 0;
    repeat (10) begin
      tick();
      if (out_valid) n++;
    end
    chk("flush no results", 64'(n), 64'h0);
    dv = $urandom;
    dir32(dv, 13, 2'b10, model(64'(dv), 13, 2'b10, 32)[31:0], "post-flush");
    for (int c = 0; c < 800; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 63) == 0;
      rnd_op();
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (10) tick();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1;
      in_valid8 = 1;
      rnd_op();
      tick();
    end
    in_valid = 0;
    in_valid8 = 0;
    #2;
    reset_n = 0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'h0);
    chk("async rst out_data", 64'(out_data), 64'h0);
    chk("async rst w8 out_valid", 64'(out_valid8), 64'h0);
    tick();
    tick();
    reset_n = 1;
    tick();
    chk("post-reset in_ready", 64'(in_ready), 64'h1);
    n = 0;
    repeat (10) begin
      tick();
      if (out_valid || out_valid8) n++;
    end
    chk("post-reset no results", 64'(n), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the 32-bit combinational left shifter.
- Supports four modes: logical left, logical right, arithmetic right and rotate right.
- One register stage per shift level, with a valid/ready elastic handshake on both sides.
- Sits between operand decode and ALU result mux on the multi-cycle shift path; accepts one operation per cycle when unstalled.

Parameters:
- WIDTH, 32, data width; must be a power of two, 4..64.
- SHW, $clog2(WIDTH), shift-amount width and number of pipeline levels L; derived, not overridden.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept the input this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  operation select:
  - 00 SLL
  - 01 SRL
  - 10 SRA
  - 11 ROR
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_mode  out  2  mode carried alongside the result (for tagging).

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits cleared, all data/mode/shamt stage registers cleared.
  - Outputs: out_valid=0, out_data=0, out_mode=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; no partial result ever appears.
- Pipeline structure:
  - Stage k (k=0..L-1) applies shift level 2^k using shamt bit k, then registers data, mode, remaining shamt bits and a valid bit.
  - Stage L-1's register drives out_data, out_valid and out_mode.
- Latency: exactly L cycles from an accepted input to out_valid with no backpressure (5 for WIDTH=32).
- Throughput: 1 operation per cycle.
- Level operation per mode at level k:
  - SLL: zero fill from LSB.
  - SRL: zero fill from MSB.
  - SRA: fill with the original operand MSB. The sign is captured at input into the stage pipeline; it is not re-read from the partially shifted data.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
  - Shift amount 0: result equals operand in all modes.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Stage k advances when its successor is empty or advancing. The last stage advances when out_valid==0 || out_ready.
  - in_ready = !v0 || advance0. It is purely combinational from stage valids and out_ready, and does not depend on in_valid.
  - Under backpressure (out_ready=0), the pipeline fills bubble-free: up to L operations held, then in_ready=0.
  - out_data and out_mode hold stable while out_valid && !out_ready.
  - Bubbles collapse: an empty stage accepts from its predecessor even when downstream is stalled.
- flush: on the clock edge where flush=1, all valid bits clear and no input is accepted that cycle (in_ready forced 0 while flush=1). flush has priority over out_ready.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle; occupancy is unchanged.
- No X propagation: when a stage is invalid, its data register may hold stale values, but out_data must be 0 whenever out_valid=0. The output is gated at the last stage register.
- Ordering: results emerge strictly in acceptance order.

Test Plan:
- WIDTH=32, SLL, in_data=32'h0000_0001, shamt=31, out_ready=1 -> out_data=32'h8000_0000 exactly 5 cycles after acceptance, out_mode=00.
- SRA in_data=32'h8000_00F0 shamt=4 -> 32'hF800_000F. SRL same operands -> 32'h0800_000F. ROR in_data=32'h0000_0001 shamt=1 -> 32'h8000_0000.
- Back-to-back 8 ops, one per cycle, mixed modes, out_ready=1 -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
- Hold out_ready=0 while streaming -> exactly 5 ops accepted, then in_ready=0. Last result held stable. Release out_ready -> all 5 drain in order, one per cycle.
- Pipeline with 3 ops in flight, assert flush one cycle -> out_valid=0 next cycle, none of the 3 ever emerge. The next accepted op emerges after 5 cycles.
- Assert reset_n=0 asynchronously between edges with ops in flight -> out_valid=0 and out_data=0 immediately. WIDTH=8 instance repeats the SLL/ROR vectors with L=3 latency.
